enclave_exec_pipe: RTL
======================

ENCLAVE_EXEC_PIPE -- requirements
Module: enclave_exec_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning encrypted/decrypted word width.
REQ-002 SHALL have parameter INSTR_W, default 64, meaning instruction width, taken from decrypted bits [INSTR_W-1:0], INSTR_W <= DATA_W.
REQ-003 SHALL have parameter RESULT_W, default 64, meaning execution result width.
REQ-004 SHALL have parameter DEPTH, default 4, meaning input FIFO entries, power of two, >= 2.
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles per engine or core phase.
REQ-006 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  encrypted instruction word.
- in_iv  in  128  CTR IV, stored alongside in_data.
- in_valid  in  1  input offer.
- in_ready  out  1  FIFO not full and not locked.
- dec_start  out  1  one-cycle pulse to decrypt engine.
- dec_data  out  DATA_W  FIFO head data, held through DECRYPT.
- dec_iv  out  128  FIFO head IV, held through DECRYPT.
- dec_out  in  DATA_W  plaintext, valid when dec_done.
- dec_done  in  1  engine completion pulse.
- core_valid  out  1  instruction valid to core, held through EXEC.
- core_instr  out  INSTR_W  decrypted instruction.
- core_result  in  RESULT_W  core result, valid when core_done.
- core_done  in  1  core completion pulse.
- res_data  out  RESULT_W  captured result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- err  out  1  one-cycle pulse on timeout.
- tamper  in  1  tamper detected, level-sensitive.
- locked  out  1  sticky tamper lock.

Function
REQ-007 SHALL accept a word when in_valid && in_ready, writing {in_iv, in_data} into the FIFO that cycle.
REQ-008 SHALL implement FSM states IDLE, DECRYPT, EXEC, OUTPUT, LOCKED.
REQ-009 IDLE with FIFO non-empty SHALL pop the head, pulse dec_start for one cycle and enter DECRYPT on the next edge.
REQ-010 DECRYPT on dec_done SHALL register dec_out[INSTR_W-1:0] into core_instr and enter EXEC with core_valid = 1 on the next cycle.
REQ-011 EXEC on core_done SHALL register core_result into res_data, drop core_valid, set res_valid and enter OUTPUT.
REQ-012 OUTPUT SHALL hold res_valid and res_data stable until res_ready, then clear res_valid and return to IDLE.
REQ-013 Minimum latency from in_valid to res_valid SHALL be 4 cycles plus engine and core latency.
REQ-014 SHALL run a phase counter cleared on entry to DECRYPT and to EXEC; reaching TIMEOUT without dec_done/core_done SHALL pulse err, zero the decrypted register, drop core_valid and return to IDLE, discarding that word.
REQ-015 dec_done outside DECRYPT and core_done outside EXEC SHALL be ignored.
REQ-016 FIFO full SHALL deassert in_ready; a push and a pop in the same cycle when full SHALL both succeed.
REQ-017 FIFO pointers SHALL carry one extra wrap bit and wrap modulo DEPTH.
REQ-018 tamper = 1 in any state SHALL enter LOCKED on the next edge, with top priority over all other events.
REQ-019 On entering LOCKED, SHALL zero the FIFO contents, pointers, decrypted register and res_data; res_valid, core_valid, dec_start and in_ready SHALL read 0; locked SHALL read 1.
REQ-020 LOCKED SHALL be left only by resetn, not by tamper deasserting.

Reset
REQ-021 resetn low SHALL asynchronously force IDLE and empty the FIFO.
REQ-022 resetn low SHALL force locked, err, res_valid, core_valid and dec_start to 0, and res_data and core_instr to 0.
REQ-023 Reset mid-operation SHALL discard all in-flight words; no partial result SHALL be emitted.

Structure
REQ-024 The state encoding and the default widths SHALL reside in shared package enclave_pkg.
REQ-025 The FIFO SHALL be a sub-module enclave_fifo, parametrised by width and DEPTH, with a synchronous clear input used for the tamper flush.

Verification
REQ-026 Push 0xA5..A5 and IV 0x01; engine returns 0x...0013 after 3 cycles; core returns 0x42 after 2 cycles -> res_data = 0x42, res_valid = 1 until res_ready.
REQ-027 Push 5 words with DEPTH = 4 and the engine stalled -> in_ready = 0 after the 4th; the 5th is accepted after the first pop.
REQ-028 Engine never asserts dec_done -> err pulses once, TIMEOUT+1 cycles after dec_start; the next FIFO word is processed.
REQ-029 Assert tamper during EXEC with 2 words queued -> locked = 1 next cycle, in_ready = 0, res_data = 0, no res_valid; state persists after tamper drops.
REQ-030 Hold res_ready = 0 for 10 cycles in OUTPUT -> res_data stable, no new dec_start; release -> next word starts.
REQ-031 Assert resetn = 0 mid-DECRYPT -> all outputs return to reset values asynchronously; a later late dec_done is ignored.

Source files
------------

// File: rtl/enclave_pkg.sv
// Shared definitions for the enclave execution pipeline.
// Holds the default widths and the control state encoding.
package enclave_pkg;

  localparam int DEF_DATA_W   = 128;
  localparam int DEF_INSTR_W  = 64;
  localparam int DEF_RESULT_W = 64;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_TIMEOUT  = 255;
  localparam int IV_W         = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECRYPT = 3'd1,
    ST_EXEC    = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_LOCKED  = 3'd4
  } state_e;

endpackage

// File: rtl/enclave_exec_pipe_if.sv
// Bundles the input, engine, core, result and tamper signals of the pipeline.
// The master modport is the pipeline side; slave is its environment.
interface enclave_exec_pipe_if
  import enclave_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int RESULT_W = DEF_RESULT_W
);

  logic [DATA_W-1:0]   in_data;
  logic [IV_W-1:0]     in_iv;
  logic                in_valid;
  logic                in_ready;

  logic                dec_start;
  logic [DATA_W-1:0]   dec_data;
  logic [IV_W-1:0]     dec_iv;
  logic [DATA_W-1:0]   dec_out;
  logic                dec_done;

  logic                core_valid;
  logic [INSTR_W-1:0]  core_instr;
  logic [RESULT_W-1:0] core_result;
  logic                core_done;

  logic [RESULT_W-1:0] res_data;
  logic                res_valid;
  logic                res_ready;

  logic                err;
  logic                tamper;
  logic                locked;

  modport master (
    input  in_data, in_iv, in_valid, dec_out, dec_done,
           core_result, core_done, res_ready, tamper,
    output in_ready, dec_start, dec_data, dec_iv, core_valid,
           core_instr, res_data, res_valid, err, locked
  );

  modport slave (
    output in_data, in_iv, in_valid, dec_out, dec_done,
           core_result, core_done, res_ready, tamper,
    input  in_ready, dec_start, dec_data, dec_iv, core_valid,
           core_instr, res_data, res_valid, err, locked
  );

endinterface

// File: rtl/enclave_fifo.sv
// Input word FIFO with wrap-bit pointers and a synchronous clear that
// flushes both pointers and the stored contents.
module enclave_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: rtl/enclave_exec_pipe.sv
// Enclave execution pipeline: queues encrypted words, hands them to an external
// decrypt engine, runs the plaintext on a core and returns the result.
module enclave_exec_pipe
  import enclave_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int RESULT_W = DEF_RESULT_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                resetn,
  enclave_exec_pipe_if.master bus
);

  localparam int ENTRY_W = IV_W + DATA_W;
  localparam int CNT_W   = $clog2(TIMEOUT + 2);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dec_start_q, dec_start_d;
  logic [DATA_W-1:0]   dec_data_q, dec_data_d;
  logic [IV_W-1:0]     dec_iv_q, dec_iv_d;
  logic                core_valid_q, core_valid_d;
  logic [INSTR_W-1:0]  core_instr_q, core_instr_d;
  logic [RESULT_W-1:0] res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;
  logic                err_q, err_d;
  logic                locked_q, locked_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                phase_expired;

  assign bus.in_ready = !fifo_full && !locked_q;
  assign fifo_push    = bus.in_valid && bus.in_ready;
  assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty && !bus.tamper;
  assign phase_expired = (cnt_q == CNT_W'(TIMEOUT));

  enclave_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (bus.tamper),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({bus.in_iv, bus.in_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dec_start_d  = 1'b0;
    dec_data_d   = dec_data_q;
    dec_iv_d     = dec_iv_q;
    core_valid_d = core_valid_q;
    core_instr_d = core_instr_q;
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    err_d        = 1'b0;
    locked_d     = locked_q;

    // Tamper overrides every phase and scrubs anything derived from plaintext.
    if (bus.tamper) begin
      state_d      = ST_LOCKED;
      locked_d     = 1'b1;
      cnt_d        = '0;
      dec_data_d   = '0;
      dec_iv_d     = '0;
      core_valid_d = 1'b0;
      core_instr_d = '0;
      res_data_d   = '0;
      res_valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {dec_iv_d, dec_data_d} = fifo_rdata;
            dec_start_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_DECRYPT;
          end
        end
        ST_DECRYPT: begin
          if (bus.dec_done) begin
            core_instr_d = bus.dec_out[INSTR_W-1:0];
            core_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_EXEC;
          end else if (phase_expired) begin
            err_d        = 1'b1;
            core_instr_d = '0;
            core_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (bus.core_done) begin
            res_data_d   = bus.core_result;
            res_valid_d  = 1'b1;
            core_valid_d = 1'b0;
            state_d      = ST_OUTPUT;
          end else if (phase_expired) begin
            err_d        = 1'b1;
            core_instr_d = '0;
            core_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (bus.res_ready) begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dec_start_q  <= 1'b0;
      dec_data_q   <= '0;
      dec_iv_q     <= '0;
      core_valid_q <= 1'b0;
      core_instr_q <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dec_start_q  <= dec_start_d;
      dec_data_q   <= dec_data_d;
      dec_iv_q     <= dec_iv_d;
      core_valid_q <= core_valid_d;
      core_instr_q <= core_instr_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.dec_start  = dec_start_q;
  assign bus.dec_data   = dec_data_q;
  assign bus.dec_iv     = dec_iv_q;
  assign bus.core_valid = core_valid_q;
  assign bus.core_instr = core_instr_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.err        = err_q;
  assign bus.locked     = locked_q;

endmodule
